// File: rtl/cpu_pkg.sv
// Shared types and constants for the 5-stage MIPS pipeline.
package cpu_pkg;

  // Exception codes, matching CP0 Cause.ExcCode
  typedef enum logic [4:0] {
    ExcNone = 5'd0,
    ExcAdel = 5'd4,
    ExcAdes = 5'd5,
    ExcRi   = 5'd10,
    ExcOv   = 5'd12
  } exc_code_e;

  localparam logic [31:0] PcInit  = 32'h0000_3000;
  localparam logic [31:0] ImBase  = 32'h0000_3000;
  localparam logic [31:0] ImBytes = 32'h0000_4000;
  localparam logic [31:0] Nop     = 32'h0000_0000;

  // Fetch-to-decode payload, reused by later pipeline registers
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        bd;
    logic [4:0]  exc;
  } fd_bundle_t;

endpackage

// File: rtl/fetch_addr_check.sv
// Combinational fetch-address legality check (alignment and IM range).
module fetch_addr_check
  import cpu_pkg::*;
#(
  parameter logic [31:0] IM_BASE  = ImBase,
  parameter logic [31:0] IM_BYTES = ImBytes,
  parameter logic [4:0]  EXC_ADEL = ExcAdel
) (
  input  logic [31:0] pc_i,
  output logic        bad_o,
  output logic [4:0]  exc_o
);

  // 33-bit compare so IM_BASE + IM_BYTES cannot wrap
  logic [32:0] pc_ext;
  logic [32:0] lo_ext;
  logic [32:0] hi_ext;
  logic        misaligned;
  logic        out_of_range;

  // Flag misaligned or out-of-range fetches and pick the matching code
  always_comb begin
    pc_ext       = {1'b0, pc_i};
    lo_ext       = {1'b0, IM_BASE};
    hi_ext       = {1'b0, IM_BASE} + {1'b0, IM_BYTES};
    misaligned   = |pc_i[1:0];
    out_of_range = (pc_ext < lo_ext) || (pc_ext >= hi_ext);
    bad_o        = misaligned || out_of_range;
    exc_o        = bad_o ? EXC_ADEL : ExcNone;
  end

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures fetched instruction and PC, tags fetch
// exceptions and delay slots, applies stall/flush, counts stalled cycles.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] PC_INIT  = PcInit,
  parameter logic [31:0] IM_BASE  = ImBase,
  parameter logic [31:0] IM_BYTES = ImBytes,
  parameter logic [4:0]  EXC_ADEL = ExcAdel
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        d_is_branch,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  output logic        npc_en,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        id_valid,
  output logic        id_bd,
  output logic [4:0]  id_exc,
  output logic [31:0] stall_cnt
);

  fd_bundle_t  fd_q, fd_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        fetch_bad;
  logic [4:0]  fetch_exc;

  fetch_addr_check #(
    .IM_BASE  (IM_BASE),
    .IM_BYTES (IM_BYTES),
    .EXC_ADEL (EXC_ADEL)
  ) u_fetch_addr_check (
    .pc_i  (if_pc),
    .bad_o (fetch_bad),
    .exc_o (fetch_exc)
  );

  // Flush must still let the PC take the exception/eret target
  assign npc_en = ~stall | flush;

  // Next-state selection: flush > stall > normal advance
  always_comb begin
    fd_d        = fd_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      // Keep the PC so EPC still has a meaningful source
      fd_d.pc    = if_pc;
      fd_d.instr = Nop;
      fd_d.valid = 1'b0;
      fd_d.bd    = 1'b0;
      fd_d.exc   = ExcNone;
    end else if (stall) begin
      if (stall_cnt_q != 32'hFFFF_FFFF) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
    end else begin
      fd_d.pc    = if_pc;
      fd_d.valid = 1'b1;
      fd_d.bd    = d_is_branch;
      // A bad fetch becomes a nop so decode sees no side effects
      fd_d.instr = fetch_bad ? Nop : if_instr;
      fd_d.exc   = fetch_exc;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      fd_q.pc     <= PC_INIT;
      fd_q.instr  <= Nop;
      fd_q.valid  <= 1'b0;
      fd_q.bd     <= 1'b0;
      fd_q.exc    <= ExcNone;
      stall_cnt_q <= 32'd0;
    end else begin
      fd_q        <= fd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign id_pc     = fd_q.pc;
  assign id_instr  = fd_q.instr;
  assign id_valid  = fd_q.valid;
  assign id_bd     = fd_q.bd;
  assign id_exc    = fd_q.exc;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/if_id_reg.md
Name: if_id_reg

Overview:
Pipeline register between the fetch stage (PC register plus instruction memory) and the decode stage of the 5-stage MIPS core.
- Captures the fetched instruction and its PC.
- Flags fetch-address exceptions (AdEL) and marks branch delay slots.
- Applies hazard-unit stalls and exception/eret flushes.
- Drives the PC register's update enable.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
PC_INIT, 32'h0000_3000, id_pc value after reset; equals the PC register's reset value.
IM_BASE, 32'h0000_3000, lowest legal fetch address.
IM_BYTES, 32'h0000_4000, instruction memory size in bytes; legal range is [IM_BASE, IM_BASE+IM_BYTES).
EXC_ADEL, 5'd4, exception code for a misaligned or out-of-range fetch.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hazard unit: hold F and D this cycle
flush  input  1  exception/eret: replace D contents with a bubble
d_is_branch  input  1  the instruction now in D is a branch or jump, so the F instruction is its delay slot
if_pc  input  32  PC of the instruction in F
if_instr  input  32  instruction memory read data for if_pc
npc_en  output  1  update enable for the PC register; equals ~stall | flush (combinational)
id_pc  output  32  registered PC for D
id_instr  output  32  registered instruction for D
id_valid  output  1  1 = real instruction, 0 = bubble
id_bd  output  1  D instruction is in a branch delay slot
id_exc  output  5  fetch exception code; 0 = none
stall_cnt  output  32  number of stalled cycles

Behaviour:
- Reset (reset=1 at a rising edge, regardless of other inputs):
  - id_pc=PC_INIT
  - id_instr=0
  - id_valid=0
  - id_bd=0
  - id_exc=0
  - stall_cnt=0
- npc_en is combinational from stall and flush. It is 1 during reset cycles too; the PC register's own reset takes precedence.
- Fetch check, combinational on if_pc. fetch_bad = (if_pc[1:0]!=0) | (if_pc<IM_BASE) | (if_pc>=IM_BASE+IM_BYTES).
  - Compute the range test in 33 bits so IM_BASE+IM_BYTES cannot wrap.
- Update priority at each rising edge: reset > flush > stall > normal.
- flush=1:
  - id_pc<=if_pc (keeps the EPC source meaningful)
  - id_instr<=0, id_valid<=0, id_bd<=0, id_exc<=0
  - stall_cnt unchanged
  - flush overrides a simultaneous stall.
- stall=1, flush=0:
  - all id_* outputs hold.
  - stall_cnt<=stall_cnt+1, saturating at 32'hFFFF_FFFF (no wrap).
- normal (stall=0, flush=0):
  - id_pc<=if_pc
  - id_valid<=1
  - id_bd<=d_is_branch
  - if fetch_bad: id_instr<=0 (nop, so decode sees no side effects) and id_exc<=EXC_ADEL.
  - otherwise: id_instr<=if_instr and id_exc<=0.
- Latency: F-to-D is exactly 1 cycle when not stalled. A stall of N cycles holds D for N extra cycles with no loss or duplication.
- Reset mid-stall or mid-flush: reset wins in that cycle and the next cycle resumes normal operation.
- No internal FSM beyond the registers. stall_cnt is the only counter.

Decomposition:
- Shared package (cpu_pkg):
  - exception code enum (EXC_NONE=0, EXC_ADEL=4, ...)
  - PC_INIT, IM_BASE, IM_BYTES constants
  - NOP=32'h0
  - typedef struct fd_bundle_t {pc, instr, valid, bd, exc}, reused by later pipeline registers.
- One sub-module: fetch_addr_check (combinational fetch_bad/exc generation), which the PC-side exception logic will reuse.
- The saturating counter stays inline.

Test Plan:
- Reset: hold reset 2 cycles with stall=1, flush=1 -> id_pc=0x3000, id_instr=0, id_valid=0, id_exc=0, stall_cnt=0, npc_en=1.
- Normal flow: if_pc=0x3000/instr=0x3C010001, then 0x3004/0x34210002, stall=0 -> D shows each pair one cycle later, id_valid=1, id_exc=0.
- Stall: stall=1 for 3 cycles while if_pc=0x3008 -> D holds 0x3004/0x34210002, npc_en=0, stall_cnt=3. On release, D gets 0x3008.
- Flush with stall: stall=1, flush=1, if_pc=0x3010 -> id_instr=0, id_valid=0, id_pc=0x3010, stall_cnt unchanged, npc_en=1.
- Fetch exceptions:
  - if_pc=0x3002 -> id_exc=4, id_instr=0.
  - if_pc=0x7000 -> id_exc=4.
  - if_pc=0x6FFC -> id_exc=0.
- Delay slot and saturation:
  - d_is_branch=1 with a normal advance -> id_bd=1; next advance with d_is_branch=0 -> id_bd=0.
  - Force stall_cnt to 0xFFFFFFFE, stall 3 cycles -> stall_cnt stays 0xFFFFFFFF.
